// File: rtl/coll_reduce_sched.sv
// Round-robin scheduler that folds requester packets into per-tag reduction slots.
// Optional build macro COLL_SAT_EN: SUM saturates at 32'hFFFFFFFF instead of wrapping.
module coll_reduce_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_SLOTS = 2,
  parameter int unsigned EXPECT    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]    in_valid,
  input  logic [NUM_REQ*72-1:0] in_pkt,
  output logic [NUM_REQ-1:0]    in_ready,
  output logic [71:0]           out_pkt,
  output logic                  valid_out,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  err_op
);
  localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(EXPECT + 1);
  localparam logic [SW-1:0] SlotMask  = SW'(NUM_SLOTS - 1);
  localparam logic [CW-1:0] ExpectCnt = CW'(EXPECT);

  typedef enum logic [1:0] {StEmpty, StAcc, StFull} slot_st_e;

  slot_st_e      r_st   [NUM_SLOTS];
  slot_st_e      w_st_d [NUM_SLOTS];
  logic [39:0]   r_hdr  [NUM_SLOTS];
  logic [39:0]   w_hdr_d[NUM_SLOTS];
  logic [31:0]   r_acc  [NUM_SLOTS];
  logic [31:0]   w_acc_d[NUM_SLOTS];
  logic [CW-1:0] r_cnt  [NUM_SLOTS];
  logic [CW-1:0] w_cnt_d[NUM_SLOTS];
  logic [RW-1:0] r_rr;
  logic [71:0]   r_out_pkt;
  logic          r_valid_out, r_done, r_err_op;
  logic [SW-1:0] r_out_slot;

  logic [SW-1:0]      w_tgt [NUM_REQ];
  logic [NUM_REQ-1:0] w_elig;
  logic               w_gnt_any;
  logic [RW-1:0]      w_gnt_idx, w_scan;
  logic [71:0]        w_gnt_pkt;
  logic [SW-1:0]      w_gnt_slot;
  logic               w_hs, w_err_d, w_full_any;
  logic [SW-1:0]      w_full_idx;

  function automatic logic [31:0] f_reduce(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      4'b0001: return (b < a) ? b : a;
      4'b0010: return (b > a) ? b : a;
      4'b0011: return a ^ b;
      default: begin
`ifdef COLL_SAT_EN
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
`else
        return a + b;
`endif
      end
    endcase
  endfunction

  // A requester is eligible only if its target slot can still take a contribution.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_tgt[i]  = in_pkt[72*i+38 +: SW] & SlotMask;
      w_elig[i] = rst & in_valid[i] & (r_st[w_tgt[i]] != StFull);
    end
  end

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_scan = RW'((32'(r_rr) + k) % NUM_REQ);
      if (!w_gnt_any && w_elig[w_scan]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

  assign w_gnt_pkt  = in_pkt[72*w_gnt_idx +: 72];
  assign w_gnt_slot = w_tgt[w_gnt_idx];
  assign w_hs       = r_valid_out & out_ready;

  always_comb begin
    in_ready = '0;
    if (w_gnt_any) in_ready[w_gnt_idx] = 1'b1;
  end

  // Slot next-state: release wins; a FULL slot is never granted, so the two never collide.
  always_comb begin
    w_err_d = 1'b0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      w_st_d[s]  = r_st[s];
      w_hdr_d[s] = r_hdr[s];
      w_acc_d[s] = r_acc[s];
      w_cnt_d[s] = r_cnt[s];
      if (w_hs && r_out_slot == SW'(s)) begin
        w_st_d[s]  = StEmpty;
        w_cnt_d[s] = '0;
      end else if (w_gnt_any && w_gnt_slot == SW'(s)) begin
        case (r_st[s])
          StEmpty: begin
            w_hdr_d[s] = w_gnt_pkt[71:32];
            w_acc_d[s] = w_gnt_pkt[31:0];
            w_cnt_d[s] = CW'(1);
            w_st_d[s]  = (EXPECT == 1) ? StFull : StAcc;
          end
          StAcc: begin
            if (w_gnt_pkt[35:32] == r_hdr[s][3:0]) begin
              w_acc_d[s] = f_reduce(r_hdr[s][3:0], r_acc[s], w_gnt_pkt[31:0]);
              w_cnt_d[s] = r_cnt[s] + CW'(1);
              if (r_cnt[s] + CW'(1) == ExpectCnt) w_st_d[s] = StFull;
            end else begin
              w_err_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr <= '0;
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        r_st[s]  <= StEmpty;
        r_hdr[s] <= '0;
        r_acc[s] <= '0;
        r_cnt[s] <= '0;
      end
    end else begin
      if (w_gnt_any) r_rr <= RW'((32'(w_gnt_idx) + 1) % NUM_REQ);
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        r_st[s]  <= w_st_d[s];
        r_hdr[s] <= w_hdr_d[s];
        r_acc[s] <= w_acc_d[s];
        r_cnt[s] <= w_cnt_d[s];
      end
    end
  end

  always_comb begin
    w_full_any = 1'b0;
    w_full_idx = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (!w_full_any && r_st[s] == StFull) begin
        w_full_any = 1'b1;
        w_full_idx = SW'(s);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_pkt   <= '0;
      r_valid_out <= 1'b0;
      r_out_slot  <= '0;
      r_done      <= 1'b0;
      r_err_op    <= 1'b0;
    end else begin
      r_done   <= w_hs;
      r_err_op <= w_err_d;
      if (w_hs) begin
        r_valid_out <= 1'b0;
      end else if (!r_valid_out && w_full_any) begin
        r_valid_out <= 1'b1;
        r_out_pkt   <= {r_hdr[w_full_idx], r_acc[w_full_idx]};
        r_out_slot  <= w_full_idx;
      end
    end
  end

  assign out_pkt   = r_out_pkt;
  assign valid_out = r_valid_out;
  assign done      = r_done;
  assign err_op    = r_err_op;

endmodule

// File: tb/tb_coll_reduce_sched.sv
// Randomized bench for coll_reduce_sched against a transaction-level reference model.
module tb_coll_reduce_sched;
  localparam int NR = 4;
  localparam int NS = 2;
  localparam int EX = 3;

  logic            clk, rst;
  logic [NR-1:0]   in_valid;
  logic [NR*72-1:0] in_pkt;
  logic [NR-1:0]   in_ready;
  logic [71:0]     out_pkt;
  logic            valid_out, out_ready, done, err_op;

  int n_tests = 0;
  int n_fail  = 0;

  coll_reduce_sched #(.NUM_REQ(NR), .NUM_SLOTS(NS), .EXPECT(EX)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pkt    (in_pkt),
    .in_ready  (in_ready),
    .out_pkt   (out_pkt),
    .valid_out (valid_out),
    .out_ready (out_ready),
    .done      (done),
    .err_op    (err_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-slot contribution count, running value and captured header.
  int          m_cnt [NS];
  bit          m_full[NS];
  logic [31:0] m_acc [NS];
  logic [39:0] m_hdr [NS];
  int          m_rr, m_oslot;
  bit          m_vo, m_done, m_err;
  logic [71:0] m_pkt;

  task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint unsigned t;
    t = 64'(a) + 64'(b);
    if (op == 4'd1) return (a < b) ? a : b;
    if (op == 4'd2) return (a > b) ? a : b;
    if (op == 4'd3) return a ^ b;
`ifdef COLL_SAT_EN
    if (t > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
`endif
    return t[31:0];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_cnt[s] = 0; m_full[s] = 0; m_acc[s] = '0; m_hdr[s] = '0;
    end
    m_rr = 0; m_oslot = 0; m_vo = 0; m_done = 0; m_err = 0; m_pkt = '0;
  endtask

  function automatic int pick(input logic [NR-1:0] v, input logic [NR*72-1:0] p);
    for (int k = 0; k < NR; k++) begin
      int i;
      int s;
      i = (m_rr + k) % NR;
      s = int'(p[72*i+38 +: 8]) % NS;
      if (v[i] && !m_full[s]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [NR-1:0] v, input logic [NR*72-1:0] p, input logic ordy);
    int g;
    int s;
    logic [71:0] q;
    bit hs;
    g = pick(v, p);
    hs = m_vo && ordy;
    m_done = hs;
    m_err = 0;
    if (hs) begin
      m_vo = 0; m_full[m_oslot] = 0; m_cnt[m_oslot] = 0;
    end else if (!m_vo) begin
      for (int k = 0; k < NS; k++) begin
        if (m_full[k] && !m_vo) begin
          m_vo = 1; m_pkt = {m_hdr[k], m_acc[k]}; m_oslot = k;
        end
      end
    end
    if (g >= 0) begin
      q = p[72*g +: 72];
      s = int'(q[45:38]) % NS;
      if (m_cnt[s] == 0) begin
        m_hdr[s] = q[71:32]; m_acc[s] = q[31:0]; m_cnt[s] = 1;
      end else if (q[35:32] == m_hdr[s][3:0]) begin
        m_acc[s] = ref_op(m_hdr[s][3:0], m_acc[s], q[31:0]); m_cnt[s]++;
      end else begin
        m_err = 1;
      end
      if (m_cnt[s] == EX) m_full[s] = 1;
      m_rr = (g + 1) % NR;
    end
  endtask

  function automatic logic [71:0] mk_pkt(input logic [7:0] tag, input logic [3:0] op,
                                         input logic [31:0] pay);
    logic [25:0] hi;
    logic [1:0]  alg;
    hi  = 26'($urandom);
    alg = 2'($urandom);
    return {hi, tag, alg, op, pay};
  endfunction

  task automatic do_cycle(input logic [NR-1:0] v, input logic [NR*72-1:0] p, input logic ordy);
    logic [NR-1:0] exp_rdy;
    int g;
    @(negedge clk);
    check_val("out_pkt",   out_pkt,   m_pkt);
    check_val("valid_out", 72'(valid_out), 72'(m_vo));
    check_val("done",      72'(done),      72'(m_done));
    check_val("err_op",    72'(err_op),    72'(m_err));
    in_valid = v; in_pkt = p; out_ready = ordy;
    #1;
    g = pick(v, p);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_val("in_ready", 72'(in_ready), 72'(exp_rdy));
    @(posedge clk);
    model_step(v, p, ordy);
  endtask

  task automatic do_reset(input logic [NR-1:0] v);
    @(negedge clk);
    in_valid = v;
    rst = 1'b0;
    #1;
    check_val("rst_in_ready",  72'(in_ready),  72'(0));
    check_val("rst_out_pkt",   out_pkt,        72'(0));
    check_val("rst_valid_out", 72'(valid_out), 72'(0));
    check_val("rst_done",      72'(done),      72'(0));
    check_val("rst_err_op",    72'(err_op),    72'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    @(posedge clk);
    model_step('0, in_pkt, 1'b0);
  endtask

  logic [NR*72-1:0] pk;
  logic [3:0]       ops[6];
  logic [3:0]       base[NS];
  logic [31:0]      pay;
  logic [7:0]       tg;

  initial begin
    rst = 1'b0; in_valid = '1; in_pkt = '0; out_ready = 1'b0;
    model_reset();
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'h3; ops[4] = 4'hF; ops[5] = 4'h7;
    repeat (2) @(posedge clk);
    do_reset('1);

    // Single requester alternating tags 1,0 with payloads 6..1.
    for (int i = 0; i < 6; i++) begin
      pk = '0;
      pk[71:0] = mk_pkt((i % 2 == 0) ? 8'd1 : 8'd0, 4'hF, 32'(6 - i));
      do_cycle(4'b0001, pk, 1'b1);
    end
    repeat (6) do_cycle('0, pk, 1'b1);

    // All requesters on one tag.
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < NR; r++) pk[72*r +: 72] = mk_pkt(8'd4, 4'h0, $urandom);
      do_cycle('1, pk, 1'b1);
    end
    repeat (4) do_cycle('0, pk, 1'b1);

    // Both slots fill and stall downstream, then release.
    for (int i = 0; i < 16; i++) begin
      for (int r = 0; r < NR; r++) pk[72*r +: 72] = mk_pkt(8'(r), 4'h3, $urandom);
      do_cycle('1, pk, 1'b0);
    end
    repeat (6) do_cycle('0, pk, 1'b1);

    // MAX 7,2, a MIN intruder, then 9.
    pk = '0;
    pk[71:0] = mk_pkt(8'd2, 4'h2, 32'd7); do_cycle(4'b0001, pk, 1'b1);
    pk[71:0] = mk_pkt(8'd2, 4'h2, 32'd2); do_cycle(4'b0001, pk, 1'b1);
    pk[71:0] = mk_pkt(8'd2, 4'h1, 32'd1); do_cycle(4'b0001, pk, 1'b1);
    pk[71:0] = mk_pkt(8'd2, 4'h2, 32'd9); do_cycle(4'b0001, pk, 1'b1);
    repeat (4) do_cycle('0, pk, 1'b1);

    // SUM near the top of the range.
    pk[71:0] = mk_pkt(8'd1, 4'hF, 32'hFFFF_FFF0); do_cycle(4'b0001, pk, 1'b1);
    pk[71:0] = mk_pkt(8'd1, 4'hF, 32'h20);        do_cycle(4'b0001, pk, 1'b1);
    pk[71:0] = mk_pkt(8'd1, 4'hF, 32'h0);         do_cycle(4'b0001, pk, 1'b1);
    repeat (4) do_cycle('0, pk, 1'b1);

    // Slot0 result pending, slot1 at count 2, then reset and refill.
    for (int i = 0; i < 5; i++) begin
      pk[71:0] = mk_pkt((i < 3) ? 8'd0 : 8'd1, 4'h0, $urandom);
      do_cycle(4'b0001, pk, 1'b0);
    end
    do_reset('0);
    for (int i = 0; i < 3; i++) begin
      pk[71:0] = mk_pkt(8'd1, 4'h0, $urandom);
      do_cycle(4'b0001, pk, 1'b1);
    end
    repeat (4) do_cycle('0, pk, 1'b1);

    // Random traffic with changing per-slot op mixes and downstream stalls.
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0)
        for (int s = 0; s < NS; s++) base[s] = ops[$urandom % 6];
      for (int r = 0; r < NR; r++) begin
        tg  = 8'($urandom);
        pay = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
        pk[72*r +: 72] = mk_pkt(tg, ($urandom % 8 == 0) ? 4'($urandom) : base[tg % NS], pay);
      end
      do_cycle(4'($urandom), pk, ($urandom % 16) < ((c / 100) % 2 == 0 ? 12 : 3));
      if (c == 1000) do_reset(4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
